// File: rtl/conv_adder_tree_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution adder tree:
//   - beat_ctl_t   : valid/first/last flags that travel alongside the data
//   - clog2        : ceiling log2 constant function
//   - tree_w/acc_w : derived datapath widths
//   - level_count  : number of elements left after a given tree level
//   - sat_max/min  : signed range limits of an OUT_W-bit result
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_ctl_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        while (v < n) begin
            v = v * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int tree_w(input int in_w, input int n_in);
        return in_w + clog2(n_in);
    endfunction

    function automatic int acc_w(input int in_w, input int n_in, input int guard);
        return tree_w(in_w, n_in) + guard;
    endfunction

    // Elements remaining after lvl pairwise levels (ceil halving each level).
    function automatic int level_count(input int n_in, input int lvl);
        int n;
        n = n_in;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 32'sd1) / 32'sd2;
        end
        return n;
    endfunction

    function automatic longint sat_max(input int out_w);
        return (64'sd1 <<< (out_w - 32'sd1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(64'sd1 <<< (out_w - 32'sd1));
    endfunction

endpackage

// File: rtl/conv_adder_tree_level.sv
// ---------------------------------------------------------------------------
// adder_tree_level
// One registered level of the pairwise adder tree. Adjacent elements are
// summed; an odd leftover element is registered unchanged. All elements are
// already at the full tree width, so the sums are exact.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   ctl_i      : beat flags entering this level
//   data_i     : N_ELEM packed elements of W bits
//   ctl_o      : beat flags, delayed one cycle
//   data_o     : ceil(N_ELEM/2) packed elements of W bits, registered
// ---------------------------------------------------------------------------
module adder_tree_level
    import conv_pkg::*;
#(
    parameter int N_ELEM = 9,
    parameter int W      = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  beat_ctl_t                        ctl_i,
    input  logic [N_ELEM*W-1:0]              data_i,
    output beat_ctl_t                        ctl_o,
    output logic [((N_ELEM+1)/2)*W-1:0]      data_o
);

    localparam int N_OUT = (N_ELEM + 1) / 2;

    logic [N_OUT*W-1:0] pair_sum;
    logic [N_OUT*W-1:0] data_d;
    logic [N_OUT*W-1:0] data_q;
    beat_ctl_t          ctl_d;
    beat_ctl_t          ctl_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if ((2 * j + 1) < N_ELEM) begin : g_add
            assign pair_sum[j*W +: W] = data_i[(2*j)*W +: W] + data_i[(2*j+1)*W +: W];
        end else begin : g_pass
            assign pair_sum[j*W +: W] = data_i[(2*j)*W +: W];
        end
    end

    // Next-state for the level registers.
    always_comb begin
        data_d = pair_sum;
        ctl_d  = ctl_i;
    end

    // Level registers; reset clears any beat in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            ctl_q  <= '0;
        end else begin
            data_q <= data_d;
            ctl_q  <= ctl_d;
        end
    end

    assign data_o = data_q;
    assign ctl_o  = ctl_q;

endmodule

// File: rtl/conv_adder_tree.sv
// ---------------------------------------------------------------------------
// conv_adder_tree
// Pipelined signed adder tree with multi-beat accumulation and a scaled,
// optionally saturated output.
// Pipeline: input register (sign-extension to tree width) -> L tree levels
// -> accumulator -> output stage. A last beat sampled at edge t produces
// done at edge t+L+2.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   enable   : beat valid this cycle
//   first    : beat starts a new accumulation (only with enable)
//   last     : beat ends the accumulation (only with enable)
//   data_in  : N_IN packed signed inputs, channel k at [k*IN_W +: IN_W]
//   output1  : signed result, zero when done is low
//   done     : one-cycle pulse per completed accumulation
//   overflow : result exceeded the OUT_W signed range, valid with done
// ---------------------------------------------------------------------------
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int N_IN      = 9,
    parameter int IN_W      = 16,
    parameter int ACC_GUARD = 8,
    parameter int OUT_W     = 24,
    parameter int SHIFT     = 0,
    parameter int SAT       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    first,
    input  logic                    last,
    input  logic [N_IN*IN_W-1:0]    data_in,
    output logic signed [OUT_W-1:0] output1,
    output logic                    done,
    output logic                    overflow
);

    localparam int L      = clog2(N_IN);
    localparam int TREE_W = tree_w(IN_W, N_IN);
    localparam int ACC_W  = acc_w(IN_W, N_IN, ACC_GUARD);
    // Comparison width wide enough for both the shifted acc and the limits.
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [CMP_W-1:0] CMP_MAX = CMP_W'(sat_max(OUT_W));
    localparam logic signed [CMP_W-1:0] CMP_MIN = CMP_W'(sat_min(OUT_W));
    localparam logic signed [OUT_W-1:0] OUT_MAX = OUT_W'(sat_max(OUT_W));
    localparam logic signed [OUT_W-1:0] OUT_MIN = OUT_W'(sat_min(OUT_W));

    // ---------------- input register ----------------
    logic [N_IN*TREE_W-1:0] in_data_d;
    logic [N_IN*TREE_W-1:0] in_data_q;
    beat_ctl_t              in_ctl_d;
    beat_ctl_t              in_ctl_q;

    // Sign-extend every channel and qualify the flags with enable.
    always_comb begin
        in_data_d = '0;
        for (int k = 0; k < N_IN; k++) begin
            in_data_d[k*TREE_W +: TREE_W] = TREE_W'($signed(data_in[k*IN_W +: IN_W]));
        end
        in_ctl_d.valid = enable;
        in_ctl_d.first = enable & first;
        in_ctl_d.last  = enable & last;
    end

    // Input register.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_data_q <= '0;
            in_ctl_q  <= '0;
        end else begin
            in_data_q <= in_data_d;
            in_ctl_q  <= in_ctl_d;
        end
    end

    // ---------------- adder tree ----------------
    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int N_I = level_count(N_IN, i);
        localparam int N_O = level_count(N_IN, i + 1);

        logic [N_I*TREE_W-1:0] lvl_in;
        beat_ctl_t             ctl_in;
        logic [N_O*TREE_W-1:0] lvl_out;
        beat_ctl_t             ctl_out;

        if (i == 0) begin : g_src
            assign lvl_in = in_data_q;
            assign ctl_in = in_ctl_q;
        end else begin : g_chain
            assign lvl_in = g_lvl[i-1].lvl_out;
            assign ctl_in = g_lvl[i-1].ctl_out;
        end

        adder_tree_level #(
            .N_ELEM (N_I),
            .W      (TREE_W)
        ) u_level (
            .clk    (clk),
            .reset  (reset),
            .ctl_i  (ctl_in),
            .data_i (lvl_in),
            .ctl_o  (ctl_out),
            .data_o (lvl_out)
        );
    end

    logic signed [TREE_W-1:0] tree_sum;
    beat_ctl_t                tree_ctl;

    assign tree_sum = $signed(g_lvl[L-1].lvl_out);
    assign tree_ctl = g_lvl[L-1].ctl_out;

    // ---------------- accumulator ----------------
    logic signed [ACC_W-1:0] tree_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic                    fwd_d;
    logic                    fwd_q;

    // Accumulate valid beats; bubbles hold acc. fwd marks acc as a final sum.
    always_comb begin
        tree_ext = ACC_W'(tree_sum);
        acc_d    = acc_q;
        fwd_d    = 1'b0;
        if (tree_ctl.valid) begin
            if (tree_ctl.first) begin
                acc_d = tree_ext;
            end else begin
                acc_d = acc_q + tree_ext;
            end
            fwd_d = tree_ctl.last;
        end else begin
            acc_d = acc_q;
            fwd_d = 1'b0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            fwd_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            fwd_q <= fwd_d;
        end
    end

    // ---------------- output stage ----------------
    logic signed [ACC_W-1:0] shifted;
    logic signed [CMP_W-1:0] v_cmp;
    logic                    above;
    logic                    below;
    logic signed [OUT_W-1:0] output1_d;
    logic signed [OUT_W-1:0] output1_q;
    logic                    done_d;
    logic                    done_q;
    logic                    overflow_d;
    logic                    overflow_q;

    // Scale, range-check and clamp or wrap the finished sum.
    always_comb begin
        shifted    = acc_q >>> SHIFT;
        v_cmp      = CMP_W'(shifted);
        above      = (v_cmp > CMP_MAX);
        below      = (v_cmp < CMP_MIN);
        output1_d  = '0;
        done_d     = 1'b0;
        overflow_d = 1'b0;
        if (fwd_q) begin
            done_d     = 1'b1;
            overflow_d = above | below;
            if ((SAT != 0) && above) begin
                output1_d = OUT_MAX;
            end else if ((SAT != 0) && below) begin
                output1_d = OUT_MIN;
            end else begin
                output1_d = v_cmp[OUT_W-1:0];
            end
        end else begin
            output1_d  = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            output1_q  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            output1_q  <= output1_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign output1  = output1_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_adder_tree.sv
// ---------------------------------------------------------------------------
// tb_conv_adder_tree
// Four configurations share one stimulus stream:
//   0: defaults (OUT_W=24, SAT=1, SHIFT=0)
//   1: OUT_W=16, SAT=1
//   2: OUT_W=16, SAT=0
//   3: SHIFT=2
// A reference model of the sum/accumulate/scale behaviour pushes the expected
// result and its due edge when a last beat is driven; a monitor pops it when
// the edge arrives and otherwise expects an idle (all-zero) output.
// ---------------------------------------------------------------------------
module tb_conv_adder_tree;

    localparam int N_IN = 9;
    localparam int IN_W = 16;
    localparam int LAT  = 6;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 first;
    logic                 last;
    logic [N_IN*IN_W-1:0] data_in;

    logic [23:0] out0;
    logic [15:0] out1;
    logic [15:0] out2;
    logic [23:0] out3;
    logic [3:0]  done_v;
    logic [3:0]  ovf_v;

    conv_adder_tree u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .first(first), .last(last),
        .data_in(data_in), .output1(out0), .done(done_v[0]), .overflow(ovf_v[0])
    );
    conv_adder_tree #(.OUT_W(16), .SAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .first(first), .last(last),
        .data_in(data_in), .output1(out1), .done(done_v[1]), .overflow(ovf_v[1])
    );
    conv_adder_tree #(.OUT_W(16), .SAT(0)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .first(first), .last(last),
        .data_in(data_in), .output1(out2), .done(done_v[2]), .overflow(ovf_v[2])
    );
    conv_adder_tree #(.SHIFT(2)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .first(first), .last(last),
        .data_in(data_in), .output1(out3), .done(done_v[3]), .overflow(ovf_v[3])
    );

    typedef struct packed {
        int              due;
        logic [3:0][23:0] out;
        logic [3:0]       ovf;
    } exp_t;

    exp_t   sb[$];
    int     checks;
    int     errors;
    int     edge_cnt;
    bit     mon_on;
    longint macc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Reference result of one configuration: {overflow, 24-bit zero-extended output}.
    function automatic logic [24:0] model(input longint acc, input int out_w, input int shift, input bit sat);
        longint v, mx, mn, r;
        logic   o;
        v  = acc >>> shift;
        mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        o  = (v > mx) || (v < mn);
        if (sat && v > mx)      r = mx;
        else if (sat && v < mn) r = mn;
        else                    r = v;
        r = r & ((64'sd1 <<< out_w) - 64'sd1);
        return {o, r[23:0]};
    endfunction

    // Monitor: compare a due result, otherwise require idle zero outputs.
    always @(negedge clk) begin : mon
        logic [3:0][23:0] obs;
        exp_t             e;
        if (mon_on) begin
            obs[0] = out0;
            obs[1] = {8'h00, out1};
            obs[2] = {8'h00, out2};
            obs[3] = out3;
            if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                for (int d = 0; d < 4; d++) begin
                    chk("done", d, {31'd0, done_v[d]}, 32'd1);
                    chk("output1", d, {8'h00, obs[d]}, {8'h00, e.out[d]});
                    chk("overflow", d, {31'd0, ovf_v[d]}, {31'd0, e.ovf[d]});
                end
            end else begin
                for (int d = 0; d < 4; d++) begin
                    chk("idle", d, {6'd0, done_v[d], ovf_v[d], obs[d]}, 32'd0);
                end
            end
        end
    end

    function automatic logic [N_IN*IN_W-1:0] fill(input logic [15:0] v);
        logic [N_IN*IN_W-1:0] d;
        for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = v;
        return d;
    endfunction

    task automatic beat(input logic [N_IN*IN_W-1:0] d, input bit f, input bit l);
        longint   sum;
        exp_t     e;
        logic [24:0] m;
        @(negedge clk);
        enable  = 1'b1;
        first   = f;
        last    = l;
        data_in = d;
        sum = 0;
        for (int k = 0; k < N_IN; k++) sum += longint'($signed(d[k*IN_W +: IN_W]));
        if (f) macc = sum;
        else   macc = macc + sum;
        macc = (macc <<< 36) >>> 36;   // wrap at ACC_W = 28
        if (l) begin
            e.due = edge_cnt + 1 + LAT;
            m = model(macc, 24, 0, 1'b1); e.out[0] = m[23:0]; e.ovf[0] = m[24];
            m = model(macc, 16, 0, 1'b1); e.out[1] = m[23:0]; e.ovf[1] = m[24];
            m = model(macc, 16, 0, 1'b0); e.out[2] = m[23:0]; e.ovf[2] = m[24];
            m = model(macc, 24, 2, 1'b1); e.out[3] = m[23:0]; e.ovf[3] = m[24];
            sb.push_back(e);
        end
    endtask

    // Disabled cycle with flags raised: must be ignored entirely.
    task automatic bubble();
        @(negedge clk);
        enable  = 1'b0;
        first   = 1'b1;
        last    = 1'b1;
        data_in = fill(16'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
            first  = 1'b0;
            last   = 1'b0;
        end
    endtask

    // One reset cycle carrying a would-be beat that reset must override.
    task automatic reset_pulse();
        @(negedge clk);
        reset   = 1'b1;
        enable  = 1'b1;
        first   = 1'b1;
        last    = 1'b1;
        data_in = fill(16'd7);
        sb.delete();
        macc = 0;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN*IN_W-1:0] rd;
        int n;
        checks = 0; errors = 0; edge_cnt = 0; mon_on = 1'b0; macc = 0;
        reset = 1'b1; enable = 1'b0; first = 1'b0; last = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;
        idle(2);

        beat(fill(16'd1), 1'b1, 1'b1);           idle(8);
        beat(fill(16'hFFFF), 1'b1, 1'b1);        idle(8);

        beat(fill(16'd100), 1'b1, 1'b0);
        beat(fill(16'd100), 1'b0, 1'b0);
        beat(fill(16'd100), 1'b0, 1'b1);         idle(8);

        beat(fill(16'd100), 1'b1, 1'b0);
        beat(fill(16'd100), 1'b0, 1'b0);
        bubble();
        bubble();
        beat(fill(16'd100), 1'b0, 1'b1);         idle(8);

        beat(fill(16'h7FFF), 1'b1, 1'b1);        idle(8);
        beat(fill(16'h8000), 1'b1, 1'b1);        idle(8);

        beat(fill(16'd50), 1'b1, 1'b0);
        reset_pulse();
        beat(fill(16'd2), 1'b1, 1'b1);           idle(8);

        reset_pulse();
        beat(fill(16'd5), 1'b0, 1'b1);           idle(8);

        for (int a = 0; a < 5; a++) begin
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) begin
                for (int k = 0; k < N_IN; k++) rd[k*IN_W +: IN_W] = 16'($urandom);
                beat(rd, (b == 0), (b == n - 1));
            end
        end
        idle(1);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
        chk("drain", 0, 32'(sb.size()), 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
